lcd_drive_ahb_regs: RTL

- AHB slave (responder) register bank that receives the RISC-V master's configuration writes for the LCD drive.
- Holds frame geometry, timing, data-count and brightness settings as static outputs for the pixel engine.
- Converts START register writes into a single-cycle start pulse.
- Tracks frame progress (busy/done/frame count) for read-back over AHB.

---
 rtl/lcd_drive_ahb_regs.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lcd_drive_ahb_regs.sv
// AHB register bank holding LCD drive configuration and frame status. Reads and writes complete with
// zero wait states. Writes to read-only or unmapped offsets stall one cycle with a two-cycle ERROR response.
module lcd_drive_ahb_regs #(
    parameter int W_ADDR       = 32,
    parameter int W_DATA       = 32,
    parameter int W_SIZE       = 12,
    parameter int W_DELAY      = 12,
    parameter int W_FRAME_SIZE = 25,
    parameter int IMG_PIX_W    = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [W_ADDR-1:0]       HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [W_DATA-1:0]       HWDATA,
    input  logic                    HREADY,
    output logic [W_DATA-1:0]       HRDATA,
    output logic                    HREADYOUT,
    output logic [1:0]              HRESP,
    input  logic                    frame_done_i,
    output logic [W_SIZE-1:0]       q_width,
    output logic [W_SIZE-1:0]       q_height,
    output logic [W_DELAY-1:0]      q_start_up_delay,
    output logic [W_DELAY-1:0]      q_vsync_cycle,
    output logic [W_DELAY-1:0]      q_vsync_delay,
    output logic [W_DELAY-1:0]      q_hsync_delay,
    output logic [W_DELAY-1:0]      q_frame_trans_delay,
    output logic [W_FRAME_SIZE-1:0] q_data_count,
    output logic                    q_br_mode,
    output logic [IMG_PIX_W-1:0]    q_br_value,
    output logic                    start_o
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] OFF_WIDTH  = 4'd0,  OFF_HEIGHT = 4'd1,  OFF_SUD   = 4'd2,  OFF_VCYC  = 4'd3;
    localparam logic [3:0] OFF_VDLY   = 4'd4,  OFF_HDLY   = 4'd5,  OFF_FTDLY = 4'd6,  OFF_DCNT  = 4'd7;
    localparam logic [3:0] OFF_BRMODE = 4'd8,  OFF_BRVAL  = 4'd9,  OFF_START = 4'd10, OFF_STATUS = 4'd11;

    logic              capture;
    logic              bad_write;
    logic              ph_vld;
    logic              ph_write;
    logic [3:0]        ph_off;
    logic              err1;
    logic              err2;
    logic              wr_en;
    logic              start_q;
    logic              start_set;
    logic [0:0]        state;
    logic              busy;
    logic              done;
    logic [7:0]        frame_cnt;
    logic [W_DATA-1:0] rd_next;
    logic              unused_ok;

    assign capture   = HSEL & HREADY & HTRANS[1];
    assign bad_write = HWRITE & (HADDR[5:2] >= OFF_STATUS);
    assign wr_en     = ph_vld & ph_write;
    assign busy      = (state == ST_RUN);
    assign start_set = wr_en & (ph_off == OFF_START) & HWDATA[0] & ~start_q;
    assign HREADYOUT = ~err1;
    assign HRESP     = {1'b0, err1 | err2};
    assign unused_ok = ^{HADDR[W_ADDR-1:6], HADDR[1:0], HSIZE, HTRANS[0]};

    // Value a register would hold after a write of d, used to forward write-then-read.
    function automatic logic [W_DATA-1:0] field_mask(input logic [3:0] off, input logic [W_DATA-1:0] d);
        logic [W_DATA-1:0] m;
        case (off)
            OFF_WIDTH, OFF_HEIGHT:                         m = W_DATA'({W_SIZE{1'b1}});
            OFF_SUD, OFF_VCYC, OFF_VDLY, OFF_HDLY, OFF_FTDLY: m = W_DATA'({W_DELAY{1'b1}});
            OFF_DCNT:                                      m = W_DATA'({W_FRAME_SIZE{1'b1}});
            OFF_BRMODE, OFF_START:                         m = W_DATA'(1'b1);
            OFF_BRVAL:                                     m = W_DATA'({IMG_PIX_W{1'b1}});
            default:                                       m = '0;
        endcase
        return d & m;
    endfunction

    always_comb begin
        rd_next = '0;
        case (HADDR[5:2])
            OFF_WIDTH:  rd_next = W_DATA'(q_width);
            OFF_HEIGHT: rd_next = W_DATA'(q_height);
            OFF_SUD:    rd_next = W_DATA'(q_start_up_delay);
            OFF_VCYC:   rd_next = W_DATA'(q_vsync_cycle);
            OFF_VDLY:   rd_next = W_DATA'(q_vsync_delay);
            OFF_HDLY:   rd_next = W_DATA'(q_hsync_delay);
            OFF_FTDLY:  rd_next = W_DATA'(q_frame_trans_delay);
            OFF_DCNT:   rd_next = W_DATA'(q_data_count);
            OFF_BRMODE: rd_next = W_DATA'(q_br_mode);
            OFF_BRVAL:  rd_next = W_DATA'(q_br_value);
            OFF_START:  rd_next = W_DATA'(start_q);
            OFF_STATUS: rd_next = W_DATA'({frame_cnt, 6'b0, done, busy});
            default:    rd_next = '0;
        endcase
        if (wr_en && (ph_off == HADDR[5:2])) begin
            rd_next = field_mask(ph_off, HWDATA);
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ph_vld              <= 1'b0;
            ph_write            <= 1'b0;
            ph_off              <= '0;
            err1                <= 1'b0;
            err2                <= 1'b0;
            HRDATA              <= '0;
            q_width             <= '0;
            q_height            <= '0;
            q_start_up_delay    <= '0;
            q_vsync_cycle       <= '0;
            q_vsync_delay       <= '0;
            q_hsync_delay       <= '0;
            q_frame_trans_delay <= '0;
            q_data_count        <= '0;
            q_br_mode           <= 1'b0;
            q_br_value          <= '0;
            start_q             <= 1'b0;
            start_o             <= 1'b0;
            state               <= ST_IDLE;
            done                <= 1'b0;
            frame_cnt           <= '0;
        end else begin
            // Rejected writes never open a normal data phase, so they cannot commit.
            ph_vld   <= capture & ~bad_write;
            ph_write <= HWRITE;
            ph_off   <= HADDR[5:2];
            err1     <= capture & bad_write;
            err2     <= err1;
            HRDATA   <= (capture && !HWRITE) ? rd_next : '0;

            if (wr_en) begin
                case (ph_off)
                    OFF_WIDTH:  q_width             <= HWDATA[W_SIZE-1:0];
                    OFF_HEIGHT: q_height            <= HWDATA[W_SIZE-1:0];
                    OFF_SUD:    q_start_up_delay    <= HWDATA[W_DELAY-1:0];
                    OFF_VCYC:   q_vsync_cycle       <= HWDATA[W_DELAY-1:0];
                    OFF_VDLY:   q_vsync_delay       <= HWDATA[W_DELAY-1:0];
                    OFF_HDLY:   q_hsync_delay       <= HWDATA[W_DELAY-1:0];
                    OFF_FTDLY:  q_frame_trans_delay <= HWDATA[W_DELAY-1:0];
                    OFF_DCNT:   q_data_count        <= HWDATA[W_FRAME_SIZE-1:0];
                    OFF_BRMODE: q_br_mode           <= HWDATA[0];
                    OFF_BRVAL:  q_br_value          <= HWDATA[IMG_PIX_W-1:0];
                    OFF_START:  start_q             <= HWDATA[0];
                    default:    ;
                endcase
            end

            start_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_set) begin
                        state   <= ST_RUN;
                        start_o <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    if (frame_done_i) begin
                        state     <= ST_IDLE;
                        done      <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
            endcase
        end
    end
endmodule
